// File: rtl/adpll_pkg.sv
// adpll_pkg: types and helpers shared across the ADPLL front end.
//   pd_state_t  - phase detector FSM states
//   err_max()   - largest magnitude a symmetric signed error of a given width may carry
//   sat_signed()- clamp a signed value to +/-err_max(width); shared with the loop
//                 filter and DCO control so every stage saturates the same way
package adpll_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REF_LEAD,
        FB_LEAD,
        WAIT_FB,
        WAIT_REF
    } pd_state_t;

    function automatic int err_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    // Symmetric clamp: the most negative two's complement code is never produced.
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] val,
                                                      input int               width);
        logic signed [31:0] hi;
        hi = err_max(width);
        if (val > hi) begin
            return hi;
        end
        if (val < -hi) begin
            return -hi;
        end
        return val;
    endfunction

endpackage

// File: rtl/phase_error_detector_if.sv
// phase_error_detector_if: bundle of the detector's measurement inputs and
// error/status outputs.
//   enable_i       - measurement enable
//   ref_i, fb_i    - asynchronous reference and divided DCO feedback
//   error_o        - signed saturated phase error, nonzero only with error_valid_o
//   error_valid_o  - one-cycle strobe per comparison
//   slip_o         - one-cycle strobe on timeout / double same-side edge
//   lock_o         - level, high while locked
// master: the side that drives enable/ref/fb; slave: the detector.
interface phase_error_detector_if #(
    parameter int ERROR_WIDTH = 8
);
    logic                          enable_i;
    logic                          ref_i;
    logic                          fb_i;
    logic signed [ERROR_WIDTH-1:0] error_o;
    logic                          error_valid_o;
    logic                          slip_o;
    logic                          lock_o;

    modport master (
        output enable_i, ref_i, fb_i,
        input  error_o, error_valid_o, slip_o, lock_o
    );

    modport slave (
        input  enable_i, ref_i, fb_i,
        output error_o, error_valid_o, slip_o, lock_o
    );
endinterface

// File: rtl/edge_sync.sv
// edge_sync: brings an asynchronous level into the gen_clk_i domain through
// SYNC_STAGES flops and produces a registered one-cycle pulse on each rising edge.
//   gen_clk_i - system clock
//   reset_i   - synchronous active-high reset, clears every flop
//   async_i   - asynchronous input level
//   pulse_o   - one-cycle pulse per synchronised rising edge
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic gen_clk_i,
    input  logic reset_i,
    input  logic async_i,
    output logic pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   pulse_q, pulse_d;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], async_i};
        prev_d  = sync_q[SYNC_STAGES-1];
        pulse_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    always_ff @(posedge gen_clk_i) begin
        if (reset_i) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/phase_error_detector.sv
// phase_error_detector: counter-based phase/frequency detector at the front of
// the ADPLL. Counts gen_clk_i cycles between synchronised rising edges of ref_i
// and fb_i and emits one signed saturated error sample per comparison
// (positive = feedback lags reference), flags cycle slips and reports lock.
//   gen_clk_i - system clock (only clock)
//   reset_i   - synchronous active-high reset
//   pd        - phase_error_detector_if.slave: enable_i, ref_i, fb_i in;
//               error_o, error_valid_o, slip_o, lock_o out (all registered)
module phase_error_detector
    import adpll_pkg::*;
#(
    parameter int ERROR_WIDTH = 8,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_TOL    = 2,
    parameter int LOCK_COUNT  = 4
) (
    input  logic                          gen_clk_i,
    input  logic                          reset_i,
    phase_error_detector_if.slave         pd
);

    localparam int                     ERR_MAX   = err_max(ERROR_WIDTH);
    localparam logic [ERROR_WIDTH-1:0] CNT_MAX   = ERROR_WIDTH'(ERR_MAX);
    localparam logic [ERROR_WIDTH-1:0] CNT_ONE   = ERROR_WIDTH'(1);
    localparam int                     LCW       = $clog2(LOCK_COUNT + 1);
    localparam logic [LCW-1:0]         LOCK_FULL = LCW'(LOCK_COUNT);

    logic ref_e;
    logic fb_e;

    pd_state_t                     state_q, state_d;
    logic [ERROR_WIDTH-1:0]        cnt_q, cnt_d;
    logic [LCW-1:0]                lock_cnt_q, lock_cnt_d;
    logic signed [ERROR_WIDTH-1:0] error_q, error_d;
    logic                          valid_q, valid_d;
    logic                          slip_q, slip_d;
    logic                          lock_q, lock_d;

    logic                          emit;
    logic                          emit_slip;
    logic signed [31:0]            emit_val;
    logic signed [31:0]            err_sat;
    logic signed [31:0]            abs_err;

    // Both paths share the same synchroniser latency, so it cancels in the
    // measured distance.
    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
        .gen_clk_i (gen_clk_i),
        .reset_i   (reset_i),
        .async_i   (pd.ref_i),
        .pulse_o   (ref_e)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
        .gen_clk_i (gen_clk_i),
        .reset_i   (reset_i),
        .async_i   (pd.fb_i),
        .pulse_o   (fb_e)
    );

    // State register and output registers
    always_ff @(posedge gen_clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            lock_cnt_q <= '0;
            error_q    <= '0;
            valid_q    <= 1'b0;
            slip_q     <= 1'b0;
            lock_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lock_cnt_q <= lock_cnt_d;
            error_q    <= error_d;
            valid_q    <= valid_d;
            slip_q     <= slip_d;
            lock_q     <= lock_d;
        end
    end

    // Next-state logic: decides when a sample is emitted and its raw value.
    // Edges take priority over the timeout, so an edge landing exactly on
    // cnt==ERR_MAX is still a clean measurement.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        emit      = 1'b0;
        emit_slip = 1'b0;
        emit_val  = '0;
        if (!pd.enable_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ref_e && fb_e) begin
                        emit = 1'b1;
                    end else if (ref_e) begin
                        cnt_d   = CNT_ONE;
                        state_d = REF_LEAD;
                    end else if (fb_e) begin
                        cnt_d   = CNT_ONE;
                        state_d = FB_LEAD;
                    end
                end
                REF_LEAD: begin
                    if (fb_e) begin
                        emit     = 1'b1;
                        emit_val = signed'(32'(cnt_q));
                        if (ref_e) begin
                            cnt_d = CNT_ONE;
                        end else begin
                            cnt_d   = '0;
                            state_d = IDLE;
                        end
                    end else if (ref_e) begin
                        emit      = 1'b1;
                        emit_slip = 1'b1;
                        emit_val  = ERR_MAX;
                        cnt_d     = CNT_ONE;
                    end else if (cnt_q == CNT_MAX) begin
                        emit      = 1'b1;
                        emit_slip = 1'b1;
                        emit_val  = ERR_MAX;
                        cnt_d     = '0;
                        state_d   = WAIT_FB;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                FB_LEAD: begin
                    if (ref_e) begin
                        emit     = 1'b1;
                        emit_val = -signed'(32'(cnt_q));
                        if (fb_e) begin
                            cnt_d = CNT_ONE;
                        end else begin
                            cnt_d   = '0;
                            state_d = IDLE;
                        end
                    end else if (fb_e) begin
                        emit      = 1'b1;
                        emit_slip = 1'b1;
                        emit_val  = -ERR_MAX;
                        cnt_d     = CNT_ONE;
                    end else if (cnt_q == CNT_MAX) begin
                        emit      = 1'b1;
                        emit_slip = 1'b1;
                        emit_val  = -ERR_MAX;
                        cnt_d     = '0;
                        state_d   = WAIT_REF;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                WAIT_FB: begin
                    if (fb_e) begin
                        state_d = IDLE;
                    end
                end
                WAIT_REF: begin
                    if (ref_e) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output logic: saturate the sample, update the lock counter and registers.
    // lock_d looks at the counter already updated by the previous strobe, which
    // places lock_o changes one cycle after the strobe that caused them.
    always_comb begin
        err_sat    = sat_signed(emit_val, ERROR_WIDTH);
        abs_err    = (err_sat < 0) ? -err_sat : err_sat;
        error_d    = emit ? ERROR_WIDTH'(err_sat) : '0;
        valid_d    = emit;
        slip_d     = emit_slip;
        lock_cnt_d = lock_cnt_q;
        if (!pd.enable_i) begin
            lock_cnt_d = '0;
        end else if (emit) begin
            if (emit_slip || (abs_err > LOCK_TOL)) begin
                lock_cnt_d = '0;
            end else if (lock_cnt_q != LOCK_FULL) begin
                lock_cnt_d = lock_cnt_q + LCW'(1);
            end
        end
        lock_d = pd.enable_i && (lock_cnt_q == LOCK_FULL);
    end

    assign pd.error_o       = error_q;
    assign pd.error_valid_o = valid_q;
    assign pd.slip_o        = slip_q;
    assign pd.lock_o        = lock_q;

endmodule
